// File: rtl/deserializer_pkg.sv
// Shared types and defaults for the serial-to-parallel deserializer.
package deserializer_pkg;

   typedef enum logic {
      RECEIVE = 1'b0,
      HOLD    = 1'b1
   } deser_state_e;

   localparam int DESER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/deser_shift_reg.sv
// MSB-first shift register with shift enable and synchronous clear (clear wins).
module deser_shift_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clock_100k,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             din,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (clr)
         q_d = '0;
      else if (shift_en)
         q_d = {q_q[WIDTH-2:0], din};
   end

   always_ff @(posedge clock_100k)
      q_q <= q_d;

   assign q = q_q;

endmodule

// File: rtl/deserializer.sv
// Collects WIDTH strobed serial bits (MSB first) into a word, then holds it until ack_in.
module deserializer
   import deserializer_pkg::*;
#(
   parameter int WIDTH = DESER_WIDTH_DEFAULT
) (
   input  logic             clock_100k,
   input  logic             reset,
   input  logic             data_in,
   input  logic             write_in,
   input  logic             ack_in,
   output logic [WIDTH-1:0] data_out,
   output logic             data_ready,
   output logic             status_out
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   deser_state_e     state_q, state_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             data_ready_q, data_ready_d;
   logic             status_q, status_d;
   logic             sr_clr, sr_shift;
   logic [WIDTH-1:0] sr_q;

   deser_shift_reg #(.WIDTH(WIDTH)) u_shift (
      .clock_100k (clock_100k),
      .clr        (sr_clr),
      .shift_en   (sr_shift),
      .din        (data_in),
      .q          (sr_q)
   );

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      data_out_d   = data_out_q;
      data_ready_d = data_ready_q;
      status_d     = status_q;
      sr_clr       = 1'b0;
      sr_shift     = 1'b0;
      case (state_q)
         RECEIVE: begin
            if (write_in) begin
               if (bit_cnt_q == LAST) begin
                  // Last bit bypasses the shift register so the word lands on this edge.
                  data_out_d   = {sr_q[WIDTH-2:0], data_in};
                  data_ready_d = 1'b1;
                  status_d     = 1'b1;
                  bit_cnt_d    = '0;
                  sr_clr       = 1'b1;
                  state_d      = HOLD;
               end else begin
                  sr_shift  = 1'b1;
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (ack_in) begin
               data_ready_d = 1'b0;
               status_d     = 1'b0;
               state_d      = RECEIVE;
            end
         end
         default: state_d = RECEIVE;
      endcase
      if (reset) begin
         state_d      = RECEIVE;
         bit_cnt_d    = '0;
         data_out_d   = '0;
         data_ready_d = 1'b0;
         status_d     = 1'b0;
         sr_clr       = 1'b1;
         sr_shift     = 1'b0;
      end
   end

   always_ff @(posedge clock_100k) begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      data_out_q   <= data_out_d;
      data_ready_q <= data_ready_d;
      status_q     <= status_d;
   end

   assign data_out   = data_out_q;
   assign data_ready = data_ready_q;
   assign status_out = status_q;

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench: driver queues expected words and ready cycle, monitor checks on data_ready rise.
module tb_deserializer;

   logic       clk = 1'b0;
   logic       reset, data_in, write_in, ack_in;
   logic [7:0] data_out;
   logic       data_ready, status_out;

   typedef struct {
      logic [7:0] word;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   ncyc  = 0;
   logic rdy_prev = 1'b0;

   deserializer #(.WIDTH(8)) dut (
      .clock_100k (clk),
      .reset      (reset),
      .data_in    (data_in),
      .write_in   (write_in),
      .ack_in     (ack_in),
      .data_out   (data_out),
      .data_ready (data_ready),
      .status_out (status_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: counts negedges, compares each new word against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      ncyc++;
      if (data_ready === 1'b1 && rdy_prev !== 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_ready", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("word", {24'd0, data_out}, {24'd0, e.word});
            chk("ready_latency", ncyc, e.cyc);
         end
      end
      rdy_prev = data_ready;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      write_in = 1'b1;
      data_in  = b;
      tick();
      write_in = 1'b0;
      data_in  = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w, input bit gaps);
      exp_t e;
      for (int i = 7; i >= 0; i--) begin
         if (gaps) repeat (i % 6) tick();
         send_bit(w[i]);
      end
      e.word = w;
      e.cyc  = ncyc + 1;
      exp_q.push_back(e);
   endtask

   task automatic ack_pulse;
      ack_in = 1'b1;
      tick();
      ack_in = 1'b0;
   endtask

   initial begin
      reset = 1'b1; data_in = 1'b0; write_in = 1'b0; ack_in = 1'b0;
      tick(); tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_data_out", {24'd0, data_out}, 32'h0);
      chk("rst_ready", {31'd0, data_ready}, 32'd0);
      chk("rst_status", {31'd0, status_out}, 32'd0);

      send_word(8'hA5, 1'b0);
      @(negedge clk);
      chk("a5_data", {24'd0, data_out}, 32'hA5);
      chk("a5_ready", {31'd0, data_ready}, 32'd1);
      chk("a5_status", {31'd0, status_out}, 32'd1);

      // Writes in HOLD must be ignored.
      repeat (10) send_bit(1'b0);
      @(negedge clk);
      chk("hold_data", {24'd0, data_out}, 32'hA5);
      chk("hold_ready", {31'd0, data_ready}, 32'd1);

      // Strobe coincident with ack is dropped; a leaked 0 would corrupt the FF word.
      ack_in = 1'b1; write_in = 1'b1; data_in = 1'b0;
      tick();
      ack_in = 1'b0; write_in = 1'b0;
      @(negedge clk);
      chk("ack_ready", {31'd0, data_ready}, 32'd0);
      chk("ack_status", {31'd0, status_out}, 32'd0);
      chk("ack_data_kept", {24'd0, data_out}, 32'hA5);

      send_word(8'hFF, 1'b0);
      @(negedge clk);
      chk("ff_data", {24'd0, data_out}, 32'hFF);
      ack_pulse();

      send_word(8'h3C, 1'b1);
      @(negedge clk);
      chk("3c_data", {24'd0, data_out}, 32'h3C);
      ack_pulse();

      // Reset mid-word: stale bits must not leak into the next word.
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_data", {24'd0, data_out}, 32'h0);
      chk("mid_rst_ready", {31'd0, data_ready}, 32'd0);
      chk("mid_rst_status", {31'd0, status_out}, 32'd0);
      send_word(8'h81, 1'b0);
      @(negedge clk);
      chk("81_data", {24'd0, data_out}, 32'h81);
      ack_pulse();

      // ack held through RECEIVE: no effect until the word completes, then clears it.
      ack_in = 1'b1;
      send_word(8'h5A, 1'b0);
      @(negedge clk);
      chk("5a_ready", {31'd0, data_ready}, 32'd1);
      chk("5a_data", {24'd0, data_out}, 32'h5A);
      @(negedge clk);
      chk("5a_cleared", {31'd0, data_ready}, 32'd0);
      chk("5a_status", {31'd0, status_out}, 32'd0);
      ack_in = 1'b0;

      repeat (3) tick();
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
